// File: rtl/mem_stage.sv
// MEM stage of a five-stage MIPS pipeline: waits for data-SRAM responses, aligns load data,
// forwards to ID and hands completed instructions to WB, discarding responses orphaned by a flush.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 194,
  parameter int MS_TO_WS_BUS_WD = 158
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       ws_flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [40:0]                ms_to_ds_bus,
  output logic                       ms_load_block
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;

  state_t                     state, state_next;
  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  logic [31:0]                buffer;

  // WB-format field positions: pc[31:0], final_result[63:32], dest[68:64], gr_we[72:69],
  // everything above passes through untouched.
  logic [31:0] rt_value, alu_result, pc, final_result, load_data, word;
  logic        mem_req, is_load, accept, accept_mem;
  logic [2:0]  load_op;
  logic [3:0]  gr_we_in, gr_we_out, merge_mask;
  logic [4:0]  dest;
  logic [1:0]  addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rt_value   = bus_q[193:162];
  assign mem_req    = bus_q[161];
  assign load_op    = bus_q[160:158];
  assign gr_we_in   = bus_q[72:69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign pc         = bus_q[31:0];
  assign addr       = alu_result[1:0];
  assign is_load    = mem_req && (gr_we_in != 4'b0000);

  assign ms_ready_go    = !mem_req || (state == HOLD) || (state == WAIT && data_sram_data_ok);
  assign ms_allowin     = (state != DISCARD) && (!ms_valid || (ms_ready_go && ws_allowin));
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_load_block  = ms_valid && is_load && !ms_ready_go;
  assign accept         = ms_allowin && es_to_ms_valid && !ws_flush;
  assign accept_mem     = accept && es_to_ms_bus[161];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ms_valid <= 1'b0;
      bus_q    <= '0;
      buffer   <= '0;
    end else begin
      state <= state_next;
      if (ws_flush)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= es_to_ms_valid;
      if (ms_allowin && !ws_flush)
        bus_q <= es_to_ms_bus;
      if (state == WAIT && data_sram_data_ok && !ws_allowin && !ws_flush)
        buffer <= data_sram_rdata;
    end
  end

  // A flush while a request is in flight must still swallow its response.
  always_comb begin
    state_next = state;
    if (ws_flush) begin
      case (state)
        WAIT, DISCARD: state_next = data_sram_data_ok ? IDLE : DISCARD;
        default:       state_next = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:    if (accept_mem) state_next = WAIT;
        WAIT:    if (data_sram_data_ok) state_next = ws_allowin ? (accept_mem ? WAIT : IDLE) : HOLD;
        HOLD:    if (ws_allowin) state_next = accept_mem ? WAIT : IDLE;
        DISCARD: if (data_sram_data_ok) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign word = (state == HOLD) ? buffer : data_sram_rdata;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  // LWL/LWR merge memory bytes into rt; the mask tells WB which bytes changed.
  always_comb begin
    load_data  = word;
    merge_mask = 4'b1111;
    case (load_op)
      3'd1: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2: load_data = {24'b0, byte_sel};
      3'd3: load_data = {{16{half_sel[15]}}, half_sel};
      3'd4: load_data = {16'b0, half_sel};
      3'd5: begin
        case (addr)
          2'd0: begin load_data = {word[7:0], rt_value[23:0]};  merge_mask = 4'b1000; end
          2'd1: begin load_data = {word[15:0], rt_value[15:0]}; merge_mask = 4'b1100; end
          2'd2: begin load_data = {word[23:0], rt_value[7:0]};  merge_mask = 4'b1110; end
          default: begin load_data = word; merge_mask = 4'b1111; end
        endcase
      end
      3'd6: begin
        case (addr)
          2'd0: begin load_data = word; merge_mask = 4'b1111; end
          2'd1: begin load_data = {rt_value[31:24], word[31:8]};  merge_mask = 4'b0111; end
          2'd2: begin load_data = {rt_value[31:16], word[31:16]}; merge_mask = 4'b0011; end
          default: begin load_data = {rt_value[31:8], word[31:24]}; merge_mask = 4'b0001; end
        endcase
      end
      default: load_data = word;
    endcase
  end

  assign final_result = is_load ? load_data : alu_result;
  assign gr_we_out    = (is_load && (load_op == 3'd5 || load_op == 3'd6)) ? merge_mask : gr_we_in;

  assign ms_to_ws_bus = {bus_q[157:73], gr_we_out, dest, final_result, pc};
  assign ms_to_ds_bus = {(ms_valid ? gr_we_out : 4'b0000), dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a one-slot transaction model of the stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ws_allowin = 1'b0;
  logic         es_to_ms_valid = 1'b0;
  logic [193:0] es_to_ms_bus = '0;
  logic         ws_flush = 1'b0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         ms_allowin, ms_to_ws_valid, ms_load_block;
  logic [157:0] ms_to_ws_bus;
  logic [40:0]  ms_to_ds_bus;

  int vectors = 0;
  int miscompares = 0;

  // Model: the instruction held in MEM, whether its response arrived, and an orphaned request.
  logic         m_valid = 1'b0;
  logic [193:0] m_bus = '0;
  logic         m_got = 1'b0;
  logic [31:0]  m_data = '0;
  logic         m_discard = 1'b0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ws_flush(ws_flush),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_to_ds_bus(ms_to_ds_bus), .ms_load_block(ms_load_block)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [157:0] act, input logic [157:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [193:0] bus, input logic wsa,
                                input logic flush, input logic dok, input logic [31:0] rdata);
    es_to_ms_valid    = valid;
    es_to_ms_bus      = bus;
    ws_allowin        = wsa;
    ws_flush          = flush;
    data_sram_data_ok = dok;
    data_sram_rdata   = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [193:0] mkbus(input logic [31:0] rt, input logic mem_req, input logic [2:0] op,
                                         input logic [3:0] we, input logic [4:0] dest,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {rt, mem_req, op, 85'h0, we, dest, alu, pc};
  endfunction

  // Returns {gr_we, result} for a load of memory word w at byte offset addr.
  function automatic logic [35:0] load_result(input logic [2:0] op, input logic [1:0] addr,
                                              input logic [31:0] w, input logic [31:0] rt,
                                              input logic [3:0] we_in);
    int a;
    logic [31:0] res;
    logic [3:0]  we;
    logic [7:0]  b;
    logic [15:0] h;
    a   = int'(addr);
    res = w;
    we  = we_in;
    case (op)
      3'd1, 3'd2: begin b = w[8*a +: 8]; res = {{24{(op == 3'd1) && b[7]}}, b}; end
      3'd3, 3'd4: begin h = w[16*(a/2) +: 16]; res = {{16{(op == 3'd3) && h[15]}}, h}; end
      3'd5: for (int i = 0; i < 4; i++) begin
        we[i] = (i >= 3 - a);
        res[8*i +: 8] = we[i] ? w[8*(i-(3-a)) +: 8] : rt[8*i +: 8];
      end
      3'd6: for (int i = 0; i < 4; i++) begin
        we[i] = (i <= 3 - a);
        res[8*i +: 8] = we[i] ? w[8*(i+a) +: 8] : rt[8*i +: 8];
      end
      default: res = w;
    endcase
    return {we, res};
  endfunction

  always @(posedge clk or posedge reset) begin : model_update
    logic pend, ready, allow;
    if (reset) begin
      m_valid <= 1'b0; m_bus <= '0; m_got <= 1'b0; m_data <= '0; m_discard <= 1'b0;
    end else begin
      pend  = m_valid && m_bus[161] && !m_got;
      ready = !m_bus[161] || m_got || data_sram_data_ok;
      allow = !m_discard && (!m_valid || (ready && ws_allowin));
      if (ws_flush) begin
        m_valid   <= 1'b0;
        m_discard <= (pend || m_discard) && !data_sram_data_ok;
      end else if (m_discard) begin
        if (data_sram_data_ok) m_discard <= 1'b0;
      end else begin
        if (pend && data_sram_data_ok) begin
          m_got  <= 1'b1;
          m_data <= data_sram_rdata;
        end
        if (allow) begin
          m_valid <= es_to_ms_valid;
          if (es_to_ms_valid) begin
            m_bus <= es_to_ms_bus;
            m_got <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        is_load, ready;
    logic [35:0] lr;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
    if (reset) begin
      check_output("reset allowin", 158'(ms_allowin), 158'(1));
      check_output("reset ws_valid", 158'(ms_to_ws_valid), 158'(0));
      check_output("reset ds_bus", 158'(ms_to_ds_bus), 158'(0));
      check_output("reset load_block", 158'(ms_load_block), 158'(0));
    end else begin
      is_load = m_bus[161] && (m_bus[72:69] != 4'b0);
      ready   = !m_bus[161] || m_got || data_sram_data_ok;
      lr      = load_result(m_bus[160:158], m_bus[33:32], m_got ? m_data : data_sram_rdata,
                            m_bus[193:162], m_bus[72:69]);
      exp_res = is_load ? lr[31:0] : m_bus[63:32];
      exp_we  = is_load ? lr[35:32] : m_bus[72:69];
      check_output("ws_valid", 158'(ms_to_ws_valid), 158'(m_valid && ready));
      check_output("allowin", 158'(ms_allowin), 158'(!m_discard && (!m_valid || (ready && ws_allowin))));
      check_output("load_block", 158'(ms_load_block), 158'(m_valid && is_load && !ready));
      check_output("ds_we", 158'(ms_to_ds_bus[40:37]), 158'(m_valid ? exp_we : 4'b0));
      if (m_valid && ready) begin
        check_output("ws_bus", ms_to_ws_bus,
                     {m_bus[157:73], exp_we, m_bus[68:64], exp_res, m_bus[31:0]});
        check_output("ds_bus", 158'(ms_to_ds_bus), 158'({exp_we, m_bus[68:64], exp_res}));
      end
    end
  end

  initial begin
    logic [193:0] rbus;
    logic         pend;
    logic [3:0]   we;
    #3;
    check_output("lit reset allowin", 158'(ms_allowin), 158'(1));
    check_output("lit reset ds_bus", 158'(ms_to_ds_bus), 158'(0));
    next_cycle();
    reset = 1'b0;

    // ALU op passes straight through one cycle after acceptance
    apply_stimulus(1, mkbus(32'h0, 0, 3'd0, 4'hf, 5'd3, 32'h1234, 32'hBFC00000), 1, 0, 0, 32'h0);
    next_cycle();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check_output("lit alu valid", 158'(ms_to_ws_valid), 158'(1));
    check_output("lit alu result", 158'(ms_to_ws_bus[63:32]), 158'(32'h1234));
    check_output("lit alu pc", 158'(ms_to_ws_bus[31:0]), 158'(32'hBFC00000));
    next_cycle();

    // LB at offset 3 after three wait cycles
    apply_stimulus(1, mkbus(32'h0, 1, 3'd1, 4'hf, 5'd4, 32'h10000003, 32'hBFC00004), 1, 0, 0, 32'h0);
    next_cycle();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("lit lb block", 158'(ms_load_block), 158'(1));
      next_cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF0011;
    @(negedge clk);
    check_output("lit lb valid", 158'(ms_to_ws_valid), 158'(1));
    check_output("lit lb result", 158'(ms_to_ws_bus[63:32]), 158'(32'hFFFFFF80));
    next_cycle();
    data_sram_data_ok = 1'b0;

    // LW whose data arrives while WB is stalled
    apply_stimulus(1, mkbus(32'h0, 1, 3'd0, 4'hf, 5'd5, 32'h00000100, 32'hBFC00008), 0, 0, 0, 32'h0);
    next_cycle();
    apply_stimulus(0, es_to_ms_bus, 0, 0, 1, 32'hDEADBEEF);
    @(negedge clk);
    check_output("lit lw result", 158'(ms_to_ws_bus[63:32]), 158'(32'hDEADBEEF));
    next_cycle();
    apply_stimulus(0, es_to_ms_bus, 0, 0, 0, 32'h12345678);
    @(negedge clk);
    check_output("lit hold valid", 158'(ms_to_ws_valid), 158'(1));
    check_output("lit hold result", 158'(ms_to_ws_bus[63:32]), 158'(32'hDEADBEEF));
    next_cycle();
    ws_allowin = 1'b1;
    @(negedge clk);
    check_output("lit hold release", 158'(ms_to_ws_bus[63:32]), 158'(32'hDEADBEEF));
    next_cycle();
    @(negedge clk);
    check_output("lit hold drained", 158'(ms_to_ws_valid), 158'(0));
    next_cycle();

    // Flush while a load waits: its late response is discarded
    apply_stimulus(1, mkbus(32'h0, 1, 3'd0, 4'hf, 5'd6, 32'h00000200, 32'hBFC0000C), 1, 0, 0, 32'h0);
    next_cycle();
    apply_stimulus(0, es_to_ms_bus, 1, 1, 0, 32'h0);
    next_cycle();
    apply_stimulus(1, mkbus(32'h0, 0, 3'd0, 4'hf, 5'd7, 32'h55, 32'hBFC00010), 1, 0, 0, 32'h0);
    @(negedge clk);
    check_output("lit discard allowin", 158'(ms_allowin), 158'(0));
    next_cycle();
    apply_stimulus(0, es_to_ms_bus, 1, 0, 1, 32'hCAFEF00D);
    @(negedge clk);
    check_output("lit discard allowin2", 158'(ms_allowin), 158'(0));
    check_output("lit discard no valid", 158'(ms_to_ws_valid), 158'(0));
    check_output("lit discard ds we", 158'(ms_to_ds_bus[40:37]), 158'(0));
    next_cycle();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check_output("lit discard idle", 158'(ms_allowin), 158'(1));
    next_cycle();

    // LWL at offset 1
    apply_stimulus(1, mkbus(32'hAABBCCDD, 1, 3'd5, 4'hf, 5'd8, 32'h00000001, 32'hBFC00014), 1, 0, 0, 32'h0);
    next_cycle();
    apply_stimulus(0, es_to_ms_bus, 1, 0, 1, 32'h44332211);
    @(negedge clk);
    check_output("lit lwl result", 158'(ms_to_ws_bus[63:32]), 158'(32'h2211CCDD));
    check_output("lit lwl we", 158'(ms_to_ws_bus[72:69]), 158'(4'b1100));
    next_cycle();
    data_sram_data_ok = 1'b0;

    // Reset in the middle of a wait
    apply_stimulus(1, mkbus(32'h0, 1, 3'd0, 4'hf, 5'd9, 32'h00000300, 32'hBFC00018), 1, 0, 0, 32'h0);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_output("lit midwait allowin", 158'(ms_allowin), 158'(1));
    check_output("lit midwait block", 158'(ms_load_block), 158'(0));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_output("lit after reset allowin", 158'(ms_allowin), 158'(1));
    next_cycle();

    // Random traffic; responses only while the model has a request outstanding
    for (int n = 0; n < 3000; n++) begin
      pend = (m_valid && m_bus[161] && !m_got) || m_discard;
      case ($urandom_range(0, 3))
        0:       we = 4'h0;
        1:       we = 4'hf;
        default: we = 4'($urandom);
      endcase
      rbus = {$urandom, 1'($urandom), 3'($urandom), 85'({$urandom, $urandom, $urandom}),
              we, 5'($urandom), $urandom, $urandom};
      apply_stimulus($urandom_range(0, 99) < 60, rbus, $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 5, pend && ($urandom_range(0, 99) < 40), $urandom);
      next_cycle();
    end
    apply_stimulus(0, '0, 1, 0, 0, 32'h0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
